// File: rtl/seq_pattern_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_pattern_tx: serialises a 5-bit pattern MSB first, reps+1 times, |
// | with a valid/ready handshake. SEQ_PATTERN_TX_GAP_EN adds one idle   |
// | GAP cycle between repetitions.                                      |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module seq_pattern_tx (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] pat,
   input  logic [3:0] reps,
   input  logic       start,
   input  logic       abort,
   input  logic       dready,
   output logic       dout,
   output logic       dvalid,
   output logic       busy,
   output logic       done
);

`ifdef SEQ_PATTERN_TX_GAP_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
   } state_t;
`endif

   state_t      r_state;
   logic [4:0]  r_pat;
   logic [3:0]  r_reps;
   logic [3:0]  r_shreg;   // bits still to present after the one on dout
   logic [2:0]  r_bitcnt;
   logic [3:0]  r_repcnt;

   logic        w_last_bit;
   logic        w_last_rep;

   assign w_last_bit = (r_bitcnt == 3'd4);
   assign w_last_rep = (r_repcnt == r_reps);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_pat    <= 5'd0;
         r_reps   <= 4'd0;
         r_shreg  <= 4'd0;
         r_bitcnt <= 3'd0;
         r_repcnt <= 4'd0;
         dout     <= 1'b0;
         dvalid   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            dout    <= 1'b0;
            dvalid  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_pat    <= pat;
                     r_reps   <= reps;
                     r_shreg  <= pat[3:0];
                     r_bitcnt <= 3'd0;
                     r_repcnt <= 4'd0;
                     dout     <= pat[4];
                     dvalid   <= 1'b1;
                     busy     <= 1'b1;
                     r_state  <= S_SHIFT;
                  end
               end
               S_SHIFT: begin
                  // dvalid is always high here, so dready alone marks a transfer
                  if (dready) begin
                     if (!w_last_bit) begin
                        r_bitcnt <= r_bitcnt + 3'd1;
                        dout     <= r_shreg[3];
                        r_shreg  <= {r_shreg[2:0], 1'b0};
                     end else if (w_last_rep) begin
                        r_state <= S_IDLE;
                        dout    <= 1'b0;
                        dvalid  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        r_repcnt <= r_repcnt + 4'd1;
                        r_bitcnt <= 3'd0;
                        r_shreg  <= r_pat[3:0];
`ifdef SEQ_PATTERN_TX_GAP_EN
                        r_state  <= S_GAP;
                        dout     <= 1'b0;
                        dvalid   <= 1'b0;
`else
                        dout     <= r_pat[4];
`endif
                     end
                  end
               end
`ifdef SEQ_PATTERN_TX_GAP_EN
               S_GAP: begin
                  r_state <= S_SHIFT;
                  dout    <= r_pat[4];
                  dvalid  <= 1'b1;
               end
`endif
               default: begin
                  r_state <= S_IDLE;
                  dout    <= 1'b0;
                  dvalid  <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire
